// File: rtl/fpa_seq_if.sv
// Bundle of the sequencer's control, operand-ROM, multiplier and judge read-port signals.
// The master side is the sequencer; the slave side is the surrounding environment.
interface fpa_seq_if #(
  parameter int WIDTH   = 32,
  parameter int N_PAIRS = 4,
  parameter int ROM_AW  = 3,
  parameter int RAM_AW  = 2
);
  logic               start;
  logic               busy;
  logic               done;
  logic [N_PAIRS-1:0] err_mask;
  logic [ROM_AW-1:0]  rom_addr;
  logic               rom_rd;
  logic [WIDTH-1:0]   rom_data;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic               mul_en;
  logic               mul_rst;
  logic               mul_done;
  logic [WIDTH-1:0]   mul_z;
  logic [RAM_AW-1:0]  rd_addr;
  logic [WIDTH-1:0]   rd_data;

  modport master (
    input  start, rom_data, mul_done, mul_z, rd_addr,
    output busy, done, err_mask, rom_addr, rom_rd, mul_a, mul_b, mul_en, mul_rst, rd_data
  );

  modport slave (
    output start, rom_data, mul_done, mul_z, rd_addr,
    input  busy, done, err_mask, rom_addr, rom_rd, mul_a, mul_b, mul_en, mul_rst, rd_data
  );
endinterface

// File: rtl/fpa_seq.sv
// Pair-multiply sequencer: fetches operand pairs from a synchronous ROM, runs each through
// an external multiplier with a per-pair timeout, and keeps the products in a result buffer.
module fpa_seq #(
  parameter int               WIDTH     = 32,
  parameter int               N_PAIRS   = 4,
  parameter int               ROM_AW    = 3,
  parameter int               RAM_AW    = 2,
  parameter int               TIMEOUT   = 64,
  parameter logic [WIDTH-1:0] NAN_VALUE = 32'h7FC00000
) (
  input  logic      clk,
  input  logic      rst,
  fpa_seq_if.master bus
);
  localparam int IW = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FA   = 3'd1;
  localparam logic [2:0] ST_FB   = 3'd2;
  localparam logic [2:0] ST_LB   = 3'd3;
  localparam logic [2:0] ST_RUN  = 3'd4;
  localparam logic [2:0] ST_CLR  = 3'd5;

  logic [2:0]         state_r;
  logic [IW-1:0]      idx_r;
  logic [TW-1:0]      tcnt_r;
  logic               done_r;
  logic [N_PAIRS-1:0] err_r;
  logic [WIDTH-1:0]   mul_a_r;
  logic [WIDTH-1:0]   mul_b_r;
  logic [WIDTH-1:0]   res_r [N_PAIRS];

  logic [ROM_AW-1:0]  pair_base_s;
  logic [ROM_AW-1:0]  rom_addr_s;
  logic               rom_rd_s;
  logic               mul_en_s;
  logic               mul_rst_s;
  logic               run_hit_s;
  logic               run_to_s;
  logic               wr_en_s;
  logic [WIDTH-1:0]   wr_data_s;
  logic [N_PAIRS-1:0] idx_hot_s;
  logic [WIDTH-1:0]   rd_data_s;

  assign pair_base_s = ROM_AW'({idx_r, 1'b0});

  // Handshake strobes and ROM address decoded from the registered state only.
  always_comb begin
    rom_rd_s   = 1'b0;
    rom_addr_s = '0;
    mul_en_s   = 1'b0;
    mul_rst_s  = 1'b0;
    case (state_r)
      ST_IDLE: mul_rst_s = 1'b1;
      ST_FA: begin
        rom_rd_s   = 1'b1;
        rom_addr_s = pair_base_s;
      end
      ST_FB: begin
        rom_rd_s   = 1'b1;
        rom_addr_s = pair_base_s + ROM_AW'(1);
      end
      ST_RUN:  mul_en_s  = 1'b1;
      ST_CLR:  mul_rst_s = 1'b1;
      default: mul_rst_s = 1'b1;
    endcase
  end

  // RUN outcome: a result beats the timeout when both happen in the same cycle.
  always_comb begin
    run_hit_s = (state_r == ST_RUN) && bus.mul_done;
    run_to_s  = (state_r == ST_RUN) && !bus.mul_done && (tcnt_r == TW'(TIMEOUT - 1));
    wr_en_s   = run_hit_s || run_to_s;
    wr_data_s = run_hit_s ? bus.mul_z : NAN_VALUE;
    for (int k = 0; k < N_PAIRS; k++) begin
      idx_hot_s[k] = (idx_r == IW'(k));
    end
  end

  // Sequencer state, pair index, timeout count and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      idx_r   <= '0;
      tcnt_r  <= '0;
      done_r  <= 1'b0;
      err_r   <= '0;
      mul_a_r <= '0;
      mul_b_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_r <= ST_FA;
            done_r  <= 1'b0;
            err_r   <= '0;
            idx_r   <= '0;
          end
        end
        ST_FA: state_r <= ST_FB;
        ST_FB: begin
          mul_a_r <= bus.rom_data;
          state_r <= ST_LB;
        end
        ST_LB: begin
          mul_b_r <= bus.rom_data;
          tcnt_r  <= '0;
          state_r <= ST_RUN;
        end
        ST_RUN: begin
          if (run_hit_s) begin
            state_r <= ST_CLR;
          end else if (run_to_s) begin
            err_r   <= err_r | idx_hot_s;
            state_r <= ST_CLR;
          end else begin
            tcnt_r <= tcnt_r + TW'(1);
          end
        end
        ST_CLR: begin
          if (idx_r == IW'(N_PAIRS - 1)) begin
            done_r  <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            idx_r   <= idx_r + IW'(1);
            state_r <= ST_FA;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Result buffer; words persist across runs until their pair is rewritten.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N_PAIRS; k++) begin
        res_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_PAIRS; k++) begin
        if (wr_en_s && idx_hot_s[k]) begin
          res_r[k] <= wr_data_s;
        end
      end
    end
  end

  // Asynchronous judge read; addresses past the last pair select nothing and read 0.
  always_comb begin
    rd_data_s = '0;
    for (int k = 0; k < N_PAIRS; k++) begin
      rd_data_s = rd_data_s | (res_r[k] & {WIDTH{bus.rd_addr == RAM_AW'(k)}});
    end
  end

  assign bus.busy     = (state_r != ST_IDLE);
  assign bus.done     = done_r;
  assign bus.err_mask = err_r;
  assign bus.rom_rd   = rom_rd_s;
  assign bus.rom_addr = rom_addr_s;
  assign bus.mul_a    = mul_a_r;
  assign bus.mul_b    = mul_b_r;
  assign bus.mul_en   = mul_en_s;
  assign bus.mul_rst  = mul_rst_s;
  assign bus.rd_data  = rd_data_s;
endmodule

// File: tb/tb_fpa_seq.sv
// Directed bench for fpa_seq: three instances (defaults, TIMEOUT=8, N_PAIRS=3) sharing one
// operand ROM image, each with a behavioural multiplier of programmable latency.
module tb_fpa_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] rom [8] = '{32'h0986AB68, 32'h10385BA9, 32'h3F800000, 32'h3E800000,
                           32'h40400000, 32'h41200000, 32'h3EA00000, 32'h3F600000};
  // Pair 0 is ~2^-203 and underflows to +0; the rest are exact.
  logic [31:0] prod_tab [4] = '{32'h00000000, 32'h3E800000, 32'h41F00000, 32'h3E8C0000};

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0]       start_v = '0;
  logic [2:0][1:0]  rd_addr_v = '0;
  logic [2:0][31:0] rd_data_v;
  logic [2:0]       done_v, busy_v, mul_en_v, mul_rst_v, rom_rd_v;
  logic [2:0][3:0]  err_v;
  logic [2:0][31:0] mul_a_v;
  int lat_v  [3] = '{3, 3, 3};
  int hang_v [3] = '{-1, -1, -1};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int pair_of(input logic [31:0] a, input logic [31:0] b);
    for (int k = 0; k < 4; k++) begin
      if (a == rom[2*k] && b == rom[2*k+1]) return k;
    end
    return -1;
  endfunction

  function automatic logic [31:0] prod_of(input logic [31:0] a, input logic [31:0] b);
    int p;
    p = pair_of(a, b);
    return (p >= 0) ? prod_tab[p] : 32'hDEADBEEF;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gen_u
    localparam int NP = (g == 2) ? 3 : 4;
    localparam int TO = (g == 0) ? 64 : 8;

    fpa_seq_if #(.WIDTH(32), .N_PAIRS(NP), .ROM_AW(3), .RAM_AW(2)) ifc ();

    fpa_seq #(
      .WIDTH(32), .N_PAIRS(NP), .ROM_AW(3), .RAM_AW(2), .TIMEOUT(TO), .NAN_VALUE(32'h7FC00000)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc.master)
    );

    int ecnt = 0;
    int run_len = 0;

    assign ifc.start    = start_v[g];
    assign ifc.rd_addr  = rd_addr_v[g];
    assign rd_data_v[g] = ifc.rd_data;
    assign done_v[g]    = ifc.done;
    assign busy_v[g]    = ifc.busy;
    assign err_v[g]     = 4'(ifc.err_mask);
    assign mul_en_v[g]  = ifc.mul_en;
    assign mul_rst_v[g] = ifc.mul_rst;
    assign rom_rd_v[g]  = ifc.rom_rd;
    assign mul_a_v[g]   = ifc.mul_a;

    always @(posedge clk) begin
      if (ifc.rom_rd) ifc.rom_data <= rom[ifc.rom_addr];
    end

    // Multiplier model: done on the lat-th enabled cycle, never for the hung pair.
    always @(posedge clk) begin
      if (ifc.mul_rst) ecnt <= 0;
      else if (ifc.mul_en) ecnt <= ecnt + 1;
    end
    assign ifc.mul_done = ifc.mul_en && (lat_v[g] > 0) && (ecnt == lat_v[g] - 1) &&
                          (pair_of(ifc.mul_a, ifc.mul_b) != hang_v[g]);
    assign ifc.mul_z = prod_of(ifc.mul_a, ifc.mul_b);

    // Inside a run, every mul_rst pulse must last exactly one cycle.
    always @(negedge clk) begin
      if (rst) begin
        if (ifc.busy && ifc.mul_rst) run_len = run_len + 1;
        else if (run_len != 0) begin
          check_eq($sformatf("u%0d_mulrst_len", g), run_len, 1);
          run_len = 0;
        end
      end
    end
  end

  // Pulse start, then count edges after the accepting edge until done; start is re-raised
  // ahead of edges p1 and p2 to probe that it is ignored.
  task automatic run_seq(input int g, input int p1, input int p2, output int cyc);
    @(negedge clk);
    start_v[g] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[g] = 1'b0;
    check_eq($sformatf("u%0d_done_drop", g), done_v[g], 1'b0);
    check_eq($sformatf("u%0d_busy_on", g), busy_v[g], 1'b1);
    check_eq($sformatf("u%0d_err_clr", g), err_v[g], 4'b0000);
    cyc = 0;
    while (!done_v[g] && cyc < 1000) begin
      if (cyc + 1 == p1 || cyc + 1 == p2) start_v[g] = 1'b1;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start_v[g] = 1'b0;
    end
  endtask

  task automatic read_chk(input int g, input int a, input logic [31:0] exp, input string tag);
    rd_addr_v[g] = 2'(a);
    #1;
    check_eq($sformatf("%s_rd%0d", tag, a), rd_data_v[g], exp);
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int cyc;
    logic [31:0] exp_u0 [4];
    exp_u0 = '{32'h00000000, 32'h3E800000, 32'h41F00000, 32'h3E8C0000};

    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy_v[0], 1'b0);
    check_eq("rst_done", done_v[0], 1'b0);
    check_eq("rst_err", err_v[0], 4'b0000);
    check_eq("rst_mul_en", mul_en_v[0], 1'b0);
    check_eq("rst_mul_rst", mul_rst_v[0], 1'b1);
    check_eq("rst_rom_rd", rom_rd_v[0], 1'b0);
    rst = 1'b1;

    // Test 1: defaults, L=3 -> 4*(4+3)
    run_seq(0, 0, 0, cyc);
    check_eq("t1_cycles", cyc, 4 * (4 + 3));
    check_eq("t1_err", err_v[0], 4'b0000);
    for (int a = 0; a < 4; a++) read_chk(0, a, exp_u0[a], "t1");

    // Test 3: asynchronous reset in the RUN phase of pair 1
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    check_eq("t3_in_run", mul_en_v[0], 1'b1);
    rst = 1'b0;
    #1;
    check_eq("t3_busy", busy_v[0], 1'b0);
    check_eq("t3_done", done_v[0], 1'b0);
    check_eq("t3_mul_en", mul_en_v[0], 1'b0);
    check_eq("t3_mul_rst", mul_rst_v[0], 1'b1);
    check_eq("t3_mul_a", mul_a_v[0], 32'h00000000);
    for (int a = 0; a < 4; a++) read_chk(0, a, 32'h00000000, "t3_clr");
    @(negedge clk);
    rst = 1'b1;
    run_seq(0, 0, 0, cyc);
    check_eq("t3_cycles", cyc, 28);
    for (int a = 0; a < 4; a++) read_chk(0, a, exp_u0[a], "t3_rerun");

    // Test 4: start mid-run and on the done-setting edge are both ignored
    run_seq(0, 10, 28, cyc);
    check_eq("t4_cycles", cyc, 28);
    repeat (3) @(negedge clk);
    check_eq("t4_idle_busy", busy_v[0], 1'b0);
    check_eq("t4_idle_done", done_v[0], 1'b1);
    lat_v[0] = 4;
    run_seq(0, 0, 0, cyc);
    check_eq("t4_fresh_cycles", cyc, 4 * (4 + 4));
    for (int a = 0; a < 4; a++) read_chk(0, a, exp_u0[a], "t4");

    // Test 2: TIMEOUT=8, pair 2 never completes -> 3*(4+3) + (4+8)
    hang_v[1] = 2;
    run_seq(1, 0, 0, cyc);
    check_eq("t2_cycles", cyc, 3 * (4 + 3) + (4 + 8));
    check_eq("t2_err", err_v[1], 4'b0100);
    read_chk(1, 0, 32'h00000000, "t2");
    read_chk(1, 1, 32'h3E800000, "t2");
    read_chk(1, 2, 32'h7FC00000, "t2");
    read_chk(1, 3, 32'h3E8C0000, "t2");

    // Test 6: done arrives exactly when tcnt==TIMEOUT-1 -> result kept, no error
    hang_v[1] = -1;
    lat_v[1]  = 8;
    run_seq(1, 0, 0, cyc);
    check_eq("t6_cycles", cyc, 4 * (4 + 8));
    check_eq("t6_err", err_v[1], 4'b0000);
    read_chk(1, 2, 32'h41F00000, "t6");

    // Test 5: N_PAIRS=3, address 3 reads 0
    run_seq(2, 0, 0, cyc);
    check_eq("t5_cycles", cyc, 3 * (4 + 3));
    check_eq("t5_err", err_v[2], 4'b0000);
    for (int a = 0; a < 3; a++) read_chk(2, a, exp_u0[a], "t5");
    read_chk(2, 3, 32'h00000000, "t5_oob");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
